scan_chain_ctrl: RTL
====================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, giving the number of FF_scan stages in the controlled chain (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 7, giving the width of the internal bit counter (must hold CHAIN_LEN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one test run; sampled only in IDLE.
REQ-006 pattern  input  CHAIN_LEN  stimulus vector to shift into the chain; latched on start acceptance.
REQ-007 expected  input  CHAIN_LEN  expected capture response; latched on start acceptance.
REQ-008 SO  input  1  scan-out from the last chain stage (Q of stage CHAIN_LEN-1).
REQ-009 SE  output  1  scan enable to all chain stages (1 = shift, 0 = functional capture).
REQ-010 SD  output  1  serial scan data into stage 0.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 pass  output  1  1 when last captured equals last expected; held until next accepted start.
REQ-014 captured  output  CHAIN_LEN  response unloaded from the chain; held until next accepted start.
REQ-015 fail_count  output  8  saturating count of failed runs since reset.

Function
REQ-016 SHALL implement states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
REQ-017 IDLE -> SHIFT_IN at the edge where start=1; pattern and expected latched at that edge, bit counter cleared, captured cleared to 0, pass cleared to 0.
REQ-018 SHIFT_IN: SE=1 for exactly CHAIN_LEN cycles; in cycle k (k=0..CHAIN_LEN-1) SD = pattern[CHAIN_LEN-1-k], so pattern[i] resides in stage i after the last shift.
REQ-019 SHIFT_IN -> CAPTURE after the CHAIN_LEN-th cycle; CAPTURE lasts exactly 1 cycle with SE=0, SD=0.
REQ-020 SHIFT_OUT: SE=1 for exactly CHAIN_LEN cycles, SD=0; at edge k the controller stores SO into captured[CHAIN_LEN-1-k].
REQ-021 SHIFT_OUT -> DONE after CHAIN_LEN cycles; DONE lasts 1 cycle with done=1, then -> IDLE unconditionally.
REQ-022 pass and captured SHALL be valid (final) in the DONE cycle and remain stable through subsequent IDLE.
REQ-023 On entering DONE with captured != expected, fail_count SHALL increment by 1, saturating at 255 (no wrap).
REQ-024 Latency: start accepted at edge t -> SHIFT_IN cycles t+1..t+N, CAPTURE t+N+1, SHIFT_OUT t+N+2..t+2N+1, done=1 in cycle t+2N+2 (N=CHAIN_LEN).
REQ-025 start while busy=1 SHALL be ignored (not queued); start in the DONE cycle is ignored; start in IDLE the cycle after DONE is accepted.
REQ-026 In IDLE: SE=0, SD=0, busy=0, done=0.
REQ-027 Changes to pattern/expected after acceptance SHALL not affect the running test.

Reset
REQ-028 reset=1 at any rising edge SHALL force IDLE, SE=0, SD=0, busy=0, done=0, pass=0, captured=0, fail_count=0, counter=0.
REQ-029 reset asserted mid-run (any state) SHALL abort the run with no done pulse and no fail_count update; reset has priority over start.

Verification
REQ-030 Chain modelled with D=Q loopback, N=8, pattern=8'hA5, expected=8'hA5 -> SE high 8 cycles, low 1, high 8; done in cycle t+18; captured=8'hA5, pass=1, fail_count=0.
REQ-031 Same chain, pattern=8'hA5, expected=8'h5A -> captured=8'hA5, pass=0, fail_count=1.
REQ-032 Chain with D=~Q, pattern=8'h0F, expected=8'hF0 -> captured=8'hF0, pass=1.
REQ-033 reset pulsed in SHIFT_IN cycle 3 -> next cycle SE=0, busy=0, no done, fail_count unchanged; subsequent start runs normally.
REQ-034 start held high continuously -> runs back-to-back with one IDLE cycle between DONE and next SHIFT_IN; start pulses during busy produce no extra runs.
REQ-035 fail_count preloaded by 255 failing runs, then one more fail -> fail_count stays 255.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_chain_ctrl                                              |
// | Description : Load / capture / unload sequencer for one scan chain, with   |
// |               response compare and a saturating fail counter.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SD,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [7:0]           fail_count
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SHIFT_IN  = 3'd1;
    localparam logic [2:0] c_CAPTURE   = 3'd2;
    localparam logic [2:0] c_SHIFT_OUT = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic [CNT_W-1:0]     r_bitCnt;
    logic [CHAIN_LEN-1:0] r_pattern;
    logic [CHAIN_LEN-1:0] r_expected;
    logic [CHAIN_LEN-1:0] r_captured;
    logic                 r_pass;
    logic [7:0]           r_failCnt;
    logic                 w_lastBit;
    logic                 w_sdBit;
    logic [CHAIN_LEN-1:0] w_capNext;

    assign w_lastBit = (r_bitCnt == c_LAST);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:      if (start) w_nextState = c_SHIFT_IN;
            c_SHIFT_IN:  if (w_lastBit) w_nextState = c_CAPTURE;
            c_CAPTURE:   w_nextState = c_SHIFT_OUT;
            c_SHIFT_OUT: if (w_lastBit) w_nextState = c_DONE;
            c_DONE:      w_nextState = c_IDLE;
            default:     w_nextState = c_IDLE;
        endcase
    end

    // Bit k of a shift phase addresses position CHAIN_LEN-1-k: MSB goes in first and comes out first.
    always_comb begin
        w_sdBit   = 1'b0;
        w_capNext = r_captured;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (r_bitCnt == CNT_W'(CHAIN_LEN - 1 - i)) begin
                w_sdBit      = r_pattern[i];
                w_capNext[i] = SO;
            end
        end
    end

    assign SE         = (r_state == c_SHIFT_IN) || (r_state == c_SHIFT_OUT);
    assign SD         = (r_state == c_SHIFT_IN) && w_sdBit;
    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_DONE);
    assign pass       = r_pass;
    assign captured   = r_captured;
    assign fail_count = r_failCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_bitCnt   <= '0;
            r_pattern  <= '0;
            r_expected <= '0;
            r_captured <= '0;
            r_pass     <= 1'b0;
            r_failCnt  <= 8'd0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_pattern  <= pattern;
                        r_expected <= expected;
                        r_bitCnt   <= '0;
                        r_captured <= '0;
                        r_pass     <= 1'b0;
                    end
                end
                c_SHIFT_IN: begin
                    r_bitCnt <= w_lastBit ? '0 : r_bitCnt + CNT_W'(1);
                end
                c_CAPTURE: begin
                    r_bitCnt <= '0;
                end
                c_SHIFT_OUT: begin
                    r_captured <= w_capNext;
                    r_bitCnt   <= w_lastBit ? '0 : r_bitCnt + CNT_W'(1);
                    // Verdict is formed from the final unload bit so it is valid in the DONE cycle.
                    if (w_lastBit) begin
                        r_pass <= (w_capNext == r_expected);
                        if ((w_capNext != r_expected) && (r_failCnt != 8'hFF)) begin
                            r_failCnt <= r_failCnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
